// File: rtl/trng_hc.sv
// trng_hc: von Neumann debiased, repetition-count checked TRNG word source with a FWFT FIFO.
// Define TRNG_APT_EN to add the adaptive proportion health test (APT_WIN / APT_CUTOFF).
module trng_hc #(
  parameter int OUT_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int WARMUP_BITS = 64,
  parameter int RCT_CUTOFF  = 32,
  parameter int APT_WIN     = 64,
  parameter int APT_CUTOFF  = 48
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          en,
  input  logic                          raw_bit,
  input  logic                          raw_valid,
  input  logic                          fault_clr,
  output logic [OUT_W-1:0]              rnd_data,
  output logic                          rnd_valid,
  input  logic                          rnd_ready,
  output logic                          healthy,
  output logic                          fault,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(OUT_W);
  localparam int WW = $clog2(WARMUP_BITS + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  localparam logic [RW-1:0] RUN_ONE    = RW'(1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(RCT_CUTOFF);
  localparam logic [WW-1:0] WCNT_ONE   = WW'(1);
  localparam logic [WW-1:0] WCNT_LAST  = WW'(WARMUP_BITS - 1);
  localparam logic [BW-1:0] BCNT_ONE   = BW'(1);
  localparam logic [BW-1:0] BCNT_LAST  = BW'(OUT_W - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               have_a_q, have_a_d;
  logic               a_q, a_d;
  logic               prev_q, prev_d;
  logic [RW-1:0]      run_q, run_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [OUT_W-1:0]   word_q, word_d, word_s;
  logic [OUT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]        level_q, level_d;
  logic               acc_s, db_valid_s, rct_trip_s, apt_trip_s;
  logic               push_s, push_ok_s, pop_s, full_s;

  assign acc_s      = en & raw_valid & (state_q != ST_FAULT);
  assign db_valid_s = acc_s & have_a_q & (a_q != raw_bit);
  assign healthy    = (state_q == ST_RUN);
  assign fault      = (state_q == ST_FAULT);
  assign fifo_level = level_q;
  assign rnd_valid  = healthy & (level_q != {(AW + 1){1'b0}});
  assign rnd_data   = rnd_valid ? mem_q[rptr_q] : {OUT_W{1'b0}};
  assign pop_s      = rnd_valid & rnd_ready;
  assign full_s     = (level_q == LVL_FULL);

  // Repetition count: a run restarts at 1 on a new value or after being cleared.
  always_comb begin
    prev_d     = prev_q;
    run_d      = run_q;
    rct_trip_s = 1'b0;
    if (acc_s) begin
      prev_d = raw_bit;
      if ((run_q == {RW{1'b0}}) || (raw_bit != prev_q)) begin
        run_d = RUN_ONE;
      end else begin
        run_d = run_q + RUN_ONE;
      end
      rct_trip_s = (run_d == RUN_MAX);
    end else begin
      rct_trip_s = 1'b0;
    end
  end

`ifdef TRNG_APT_EN
  localparam int CW = $clog2(APT_WIN + 1);
  localparam logic [CW-1:0] APT_ONE  = CW'(1);
  localparam logic [CW-1:0] APT_MAX  = CW'(APT_CUTOFF);
  localparam logic [CW-1:0] APT_LAST = CW'(APT_WIN - 1);

  logic          apt_ref_q, apt_ref_d;
  logic [CW-1:0] apt_idx_q, apt_idx_d, apt_cnt_q, apt_cnt_d;

  // Adaptive proportion: the window's first bit is the reference and counts itself.
  always_comb begin
    apt_ref_d  = apt_ref_q;
    apt_idx_d  = apt_idx_q;
    apt_cnt_d  = apt_cnt_q;
    apt_trip_s = 1'b0;
    if (acc_s) begin
      if (apt_idx_q == {CW{1'b0}}) begin
        apt_ref_d = raw_bit;
        apt_cnt_d = APT_ONE;
      end else if (raw_bit == apt_ref_q) begin
        apt_cnt_d = apt_cnt_q + APT_ONE;
      end else begin
        apt_cnt_d = apt_cnt_q;
      end
      apt_trip_s = (apt_cnt_d == APT_MAX);
      apt_idx_d  = (apt_idx_q == APT_LAST) ? {CW{1'b0}} : (apt_idx_q + APT_ONE);
    end else begin
      apt_trip_s = 1'b0;
    end
    if (rct_trip_s || apt_trip_s || ((state_q == ST_RUN) && !en) ||
        ((state_q == ST_FAULT) && fault_clr)) begin
      apt_idx_d = {CW{1'b0}};
      apt_cnt_d = {CW{1'b0}};
    end else begin
      apt_idx_d = apt_idx_d;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      apt_ref_q <= 1'b0;
      apt_idx_q <= {CW{1'b0}};
      apt_cnt_q <= {CW{1'b0}};
    end else begin
      apt_ref_q <= apt_ref_d;
      apt_idx_q <= apt_idx_d;
      apt_cnt_q <= apt_cnt_d;
    end
  end
`else
  assign apt_trip_s = (APT_WIN < 32'sd0) || (APT_CUTOFF < 32'sd0);
`endif

  // Pairing, warm-up / word assembly, FIFO bookkeeping and fault handling.
  always_comb begin
    state_d   = state_q;
    have_a_d  = have_a_q;
    a_d       = a_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    word_s    = word_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    mem_d     = mem_q;
    push_s    = 1'b0;
    push_ok_s = 1'b0;

    if (acc_s) begin
      have_a_d = ~have_a_q;
      a_d      = raw_bit;
    end else begin
      have_a_d = have_a_q;
    end

    case (state_q)
      ST_WARMUP: begin
        if (!en) begin
          wcnt_d = {WW{1'b0}};
        end else if (db_valid_s) begin
          if (wcnt_q == WCNT_LAST) begin
            state_d = ST_RUN;
            wcnt_d  = {WW{1'b0}};
          end else begin
            wcnt_d = wcnt_q + WCNT_ONE;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_WARMUP;
          bcnt_d  = {BW{1'b0}};
          word_d  = {OUT_W{1'b0}};
        end else if (db_valid_s) begin
          word_s[bcnt_q] = a_q;
          if (bcnt_q == BCNT_LAST) begin
            push_s = 1'b1;
            bcnt_d = {BW{1'b0}};
            word_d = {OUT_W{1'b0}};
          end else begin
            bcnt_d = bcnt_q + BCNT_ONE;
            word_d = word_s;
          end
        end else begin
          word_d = word_q;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_WARMUP;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_WARMUP;
      end
    endcase

    push_ok_s = push_s & (~full_s | pop_s);
    if (push_ok_s) begin
      mem_d[wptr_q] = word_s;
      wptr_d        = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A trip overrides everything, including a word completing on the same edge.
    if (rct_trip_s || apt_trip_s) begin
      state_d  = ST_FAULT;
      have_a_d = 1'b0;
      wcnt_d   = {WW{1'b0}};
      bcnt_d   = {BW{1'b0}};
      word_d   = {OUT_W{1'b0}};
      wptr_d   = {AW{1'b0}};
      rptr_d   = {AW{1'b0}};
      level_d  = {(AW + 1){1'b0}};
    end else begin
      level_d = level_d;
    end
    if (!en) begin
      have_a_d = 1'b0;
    end else begin
      have_a_d = have_a_d;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= ST_WARMUP;
      have_a_q <= 1'b0;
      a_q      <= 1'b0;
      prev_q   <= 1'b0;
      run_q    <= {RW{1'b0}};
      wcnt_q   <= {WW{1'b0}};
      bcnt_q   <= {BW{1'b0}};
      word_q   <= {OUT_W{1'b0}};
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      level_q  <= {(AW + 1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {OUT_W{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      have_a_q <= have_a_d;
      a_q      <= a_d;
      prev_q   <= prev_d;
      run_q    <= (rct_trip_s || apt_trip_s) ? {RW{1'b0}} : run_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_trng_hc.sv
// Scoreboard bench for trng_hc: directed spec scenarios plus a randomized phase,
// checked against a bit-level behavioural model.
module tb_trng_hc;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;
  localparam int WARM  = 4;
  localparam int RCT   = 8;
  localparam int APT_W = 16;
  localparam int APT_C = 12;
  localparam int MW = 0, MR = 1, MF = 2;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       en = 1'b1, raw_bit = 1'b0, raw_valid = 1'b0, fault_clr = 1'b0, rnd_ready = 1'b0;
  logic [7:0] rnd_data;
  logic       rnd_valid, healthy, fault;
  logic [2:0] fifo_level;

  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;

  // Model state
  int m_state, m_have, m_a, m_prev, m_run, m_wcnt, m_nb, m_word, m_level;
  int m_apt_n, m_apt_ref, m_apt_cnt;
  logic [7:0] sb[$];

  trng_hc #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .WARMUP_BITS(WARM), .RCT_CUTOFF(RCT),
            .APT_WIN(APT_W), .APT_CUTOFF(APT_C)) dut (
    .clk(clk), .n_reset(n_reset), .en(en), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .fault_clr(fault_clr), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .healthy(healthy), .fault(fault), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = MW; m_have = 0; m_a = 0; m_prev = 0; m_run = 0; m_wcnt = 0;
    m_nb = 0; m_word = 0; m_level = 0; m_apt_n = 0; m_apt_ref = 0; m_apt_cnt = 0;
    sb.delete();
  endtask

  // One clock edge of the specified behaviour, using the inputs seen at that edge.
  task automatic model_step();
    bit pop, acc, trip, db;
    int dbit;
    if (!n_reset) begin model_reset(); return; end
    pop  = (m_state == MR) && (m_level > 0) && rnd_ready;
    acc  = en && raw_valid && (m_state != MF);
    trip = 0; db = 0; dbit = 0;
    if (acc) begin
      m_run  = (m_run == 0 || int'(raw_bit) != m_prev) ? 1 : m_run + 1;
      m_prev = int'(raw_bit);
      if (m_run >= RCT) trip = 1;
`ifdef TRNG_APT_EN
      if (m_apt_n == 0) begin m_apt_ref = int'(raw_bit); m_apt_cnt = 1; end
      else if (int'(raw_bit) == m_apt_ref) m_apt_cnt++;
      m_apt_n++;
      if (m_apt_cnt >= APT_C) trip = 1;
      if (m_apt_n == APT_W) m_apt_n = 0;
`endif
      if (m_have != 0) begin
        m_have = 0;
        if (m_a != int'(raw_bit)) begin db = 1; dbit = m_a; end
      end else begin
        m_have = 1; m_a = int'(raw_bit);
      end
    end
    if (trip) begin
      m_state = MF; m_level = 0; sb.delete(); m_have = 0; m_run = 0;
      m_wcnt = 0; m_nb = 0; m_word = 0; m_apt_n = 0; m_apt_cnt = 0;
    end else begin
      if (pop) m_level--;
      if (m_state == MW) begin
        if (!en) m_wcnt = 0;
        else if (db) begin
          m_wcnt++;
          if (m_wcnt == WARM) begin m_state = MR; m_wcnt = 0; end
        end
      end else if (m_state == MR) begin
        if (!en) begin
          m_state = MW; m_nb = 0; m_word = 0; m_apt_n = 0; m_apt_cnt = 0;
        end else if (db) begin
          m_word = m_word | (dbit << m_nb);
          m_nb++;
          if (m_nb == OUT_W) begin
            if (m_level < DEPTH) begin m_level++; sb.push_back(m_word[7:0]); end
            m_nb = 0; m_word = 0;
          end
        end
      end else if (fault_clr) begin
        m_state = MW; m_apt_n = 0; m_apt_cnt = 0;
      end
    end
    if (!en) m_have = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_bit(input logic b);
    raw_valid = 1'b1; raw_bit = b;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic send_pair(input logic a, input logic b);
    send_bit(a); send_bit(b);
  endtask

  task automatic warm_pairs(input int n);
    for (int i = 0; i < n; i++) send_pair(1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input bit pop_on_last);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i]);
      if (pop_on_last && (i == 7)) rnd_ready = 1'b1;
      send_bit(~w[i]);
    end
    if (pop_on_last) rnd_ready = 1'b0;
  endtask

  task automatic pop_one();
    rnd_ready = 1'b1; tick(); rnd_ready = 1'b0;
  endtask

  // Monitor: compares status against the model and pops the scoreboard on handshakes.
  initial begin
    while (!done) begin
      @(negedge clk);
      chk("fifo_level", 32'(fifo_level), 32'(m_level));
      chk("healthy", 32'(healthy), 32'(m_state == MR));
      chk("fault", 32'(fault), 32'(m_state == MF));
      chk("rnd_valid", 32'(rnd_valid), 32'((m_state == MR) && (m_level > 0)));
      if (rnd_valid && rnd_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop_empty: got data %0h expected no word at %0t", rnd_data, $time);
        end else begin
          chk("rnd_data", 32'(rnd_data), 32'(sb.pop_front()));
        end
      end else if (!rnd_valid) begin
        chk("rnd_data_idle", 32'(rnd_data), 32'h0);
      end
    end
  end

  logic [7:0] drain_exp [4];

  initial begin
    model_reset();
    #2;
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data", 32'(rnd_data), 32'h0);
    chk("rst_healthy", 32'(healthy), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    tick(); tick();
    n_reset = 1'b1;

    // warm-up then 0xA5
    warm_pairs(3);
    chk("warm3_healthy", 32'(healthy), 32'h0);
    warm_pairs(1);
    chk("warm4_healthy", 32'(healthy), 32'h1);
    send_word(8'hA5, 1'b0);
    chk("a5_valid", 32'(rnd_valid), 32'h1);
    chk("a5_data", 32'(rnd_data), 32'hA5);
    pop_one();

    // discard pairs interleaved with 0x3C
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send_pair(1'b0, 1'b0); else send_pair(1'b1, 1'b1);
      send_pair(((8'h3C >> i) & 8'h1) != 8'h0, ((8'h3C >> i) & 8'h1) == 8'h0);
    end
    chk("3c_level", 32'(fifo_level), 32'h1);
    chk("3c_data", 32'(rnd_data), 32'h3C);
    pop_one();

    // fill, drop, simultaneous push/pop at full
    for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0);
    chk("full_level", 32'(fifo_level), 32'h4);
    chk("full_head", 32'(rnd_data), 32'h01);
    send_word(8'h06, 1'b1);
    chk("pushpop_level", 32'(fifo_level), 32'h4);
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h06};
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(rnd_data), 32'(drain_exp[i]));
      pop_one();
    end
    chk("drain_level", 32'(fifo_level), 32'h0);

    // RCT fault with a word buffered
    send_word(8'h11, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    chk("rct_fault", 32'(fault), 32'h1);
    chk("rct_healthy", 32'(healthy), 32'h0);
    chk("rct_level", 32'(fifo_level), 32'h0);
    chk("rct_valid", 32'(rnd_valid), 32'h0);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("clr_fault", 32'(fault), 32'h0);
    warm_pairs(3);
    chk("clr_warm3", 32'(healthy), 32'h0);
    warm_pairs(1);
    chk("clr_warm4", 32'(healthy), 32'h1);

    // fault_clr ignored in RUN; en drop keeps FIFO, drops partial word
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("clr_in_run", 32'(healthy), 32'h1);
    send_word(8'h5A, 1'b0);
    send_pair(1'b0, 1'b1); send_pair(1'b1, 1'b0); send_pair(1'b1, 1'b0);
    en = 1'b0; tick();
    chk("en_low_healthy", 32'(healthy), 32'h0);
    chk("en_low_level", 32'(fifo_level), 32'h1);
    en = 1'b1;
    warm_pairs(4);
    chk("en_back_data", 32'(rnd_data), 32'h5A);
    pop_one();

    // async reset mid-word
    send_word(8'h77, 1'b0);
    send_pair(1'b1, 1'b0); send_pair(1'b0, 1'b1); send_pair(1'b1, 1'b0);
    #1;
    n_reset = 1'b0; model_reset();
    #1;
    chk("arst_valid", 32'(rnd_valid), 32'h0);
    chk("arst_data", 32'(rnd_data), 32'h0);
    chk("arst_healthy", 32'(healthy), 32'h0);
    chk("arst_level", 32'(fifo_level), 32'h0);
    tick();
    n_reset = 1'b1;
    warm_pairs(3);
    chk("arst_warm3", 32'(healthy), 32'h0);
    warm_pairs(1);
    chk("arst_warm4", 32'(healthy), 32'h1);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      en        = ($urandom_range(0, 99) < 97);
      raw_valid = ($urandom_range(0, 3) != 0);
      raw_bit   = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 50 : 70));
      rnd_ready = ($urandom_range(0, 2) == 0);
      fault_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    en = 1'b1; raw_valid = 1'b0; rnd_ready = 1'b0; fault_clr = 1'b0;

`ifdef TRNG_APT_EN
    #1;
    n_reset = 1'b0; model_reset();
    tick();
    n_reset = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("apt_pre", 32'(fault), 32'h0);
    send_bit(1'b1);
    chk("apt_fault", 32'(fault), 32'h1);
`endif

    tick(); tick();
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trng_hc.md
Name: trng_hc

Overview:
- Parametrised successor to the free-running byte TRNG core: a conditioned, health-checked random word generator.
- Takes a raw sampled entropy bit stream from the oscillator sampler, applies von Neumann debiasing and a repetition-count health test, and discards a warm-up prefix.
- Packs debiased bits into OUT_W-bit words and buffers them in a FIFO.
- Words leave through a valid/ready interface, so consumers no longer sample a free-running byte.

Parameters:
- OUT_W, 8: output word width in bits (>=2).
- FIFO_DEPTH, 4: number of buffered words (power of 2, >=2).
- WARMUP_BITS, 64: debiased bits discarded after reset, enable-rise or fault clear.
- RCT_CUTOFF, 32: repetition-count cutoff on raw bits (>=2).
- APT_WIN, 64: adaptive-proportion window in raw bits (used only with the macro).
- APT_CUTOFF, 48: adaptive-proportion cutoff (used only with the macro).

Ports:
- clk  in  1  clock.
- n_reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes the sampler path.
- raw_bit  in  1  raw entropy sample.
- raw_valid  in  1  raw_bit is valid this cycle.
- fault_clr  in  1  single-cycle pulse; leaves FAULT.
- rnd_data  out  OUT_W  FIFO head word; 0 when rnd_valid=0.
- rnd_valid  out  1  FIFO non-empty and state RUN.
- rnd_ready  in  1  consumer accepts head when rnd_valid & rnd_ready.
- healthy  out  1  state==RUN.
- fault  out  1  state==FAULT.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held.

Behaviour:
- Reset (async, n_reset=0): state WARMUP; all counters, pair latch, word register and FIFO cleared. rnd_valid=0, rnd_data=0, healthy=0, fault=0, fifo_level=0.
- Raw bits are accepted only when en=1 & raw_valid=1; all other cycles are ignored.
- Debiasing: accepted raw bits form pairs (a,b) in arrival order.
  - a!=b: emit debiased bit a.
  - a==b: discard the pair.
  - Pair-phase latch clears when en=0.
- Health test (RCT) runs on every accepted raw bit in all states except FAULT.
  - run=1 if bit differs from the previous accepted bit, else run+1.
  - On the edge where run reaches RCT_CUTOFF, state goes to FAULT.
- State machine:
  - WARMUP: debiased bits counted, not stored. WARMUP_BITS-th bit -> RUN; the next debiased bit is word bit 0.
  - RUN: debiased bits shift into the word register, first bit at bit 0 (LSB-first). On the edge accepting the OUT_W-th bit, the word is written to the FIFO and the bit count resets.
  - FAULT: raw input ignored.
  - RUN or WARMUP -> FAULT: FIFO flushed, partial word and counters cleared on the same edge.
  - FAULT -> WARMUP on fault_clr=1.
  - en falling in RUN: partial word discarded, FIFO kept, state -> WARMUP.
- FIFO: first-word-fall-through.
  - Push-to-visible latency 1 cycle; there is no bypass when empty.
  - Pop on rnd_valid & rnd_ready.
  - Full with a push and no pop: new word dropped silently, assembly continues.
  - Full with simultaneous push and pop: both accepted, level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - rnd_valid is gated by healthy, so no word is presented outside RUN.
- Simultaneous events:
  - RCT trip on the same edge as a word completion: FAULT wins, word not pushed.
  - fault_clr outside FAULT is ignored.
  - Reset mid-operation aborts everything immediately.

Optional Feature:
- Macro: TRNG_APT_EN.
- With TRNG_APT_EN defined, an adaptive proportion test runs on accepted raw bits:
  - The first bit of each APT_WIN-bit window is the reference.
  - A counter counts matches of the reference across the window.
  - Reaching APT_CUTOFF inside the window -> FAULT, with the same side effects as RCT.
  - Window restarts after APT_WIN bits, and on WARMUP entry.
- Without the macro: no APT logic; APT_WIN and APT_CUTOFF are unused.

Test Plan:
- Bench parameters for all scenarios: OUT_W=8, FIFO_DEPTH=4, WARMUP_BITS=4, RCT_CUTOFF=8.
- Warm-up and debiasing: feed 4 pairs (1,0), then bit-pairs encoding 0xA5 LSB-first ((1,0)=1, (0,1)=0) -> healthy rises after the 4th pair; rnd_valid rises 1 cycle after the 8th data pair; rnd_data=0xA5.
- Discard pairs: interleave (0,0) and (1,1) pairs between data pairs of 0x3C -> output still 0x3C, fifo_level=1.
- FIFO full and drop: hold rnd_ready=0, generate 5 words 0x01..0x05 -> fifo_level=4; pops return 0x01..0x04; 0x05 lost.
- Simultaneous push and pop at full: rnd_ready=1 on the push edge -> level stays 4, order preserved.
- RCT fault: 8 consecutive raw 1s -> fault=1 next cycle, healthy=0, fifo_level=0, rnd_valid=0. Pulse fault_clr -> WARMUP; after 4 good pairs healthy=1.
- Async reset mid-word: assert n_reset=0 after 3 data pairs -> all outputs 0 immediately. After release, warm-up restarts from 0. With TRNG_APT_EN and APT_WIN=16, APT_CUTOFF=12, drive 12 ones within 16 bits (runs under 8) -> fault=1.
